// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared segment codes and the nibble-to-segment decode for the
// seven-segment scan driver. Codes are active-high, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Values 10..15 only light when hex display is enabled; otherwise blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble,
                                            input logic       hex_mode);
    logic [6:0] code;
    case (nibble)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = hex_mode ? SEG_A : SEG_BLANK;
      4'hB:    code = hex_mode ? SEG_B : SEG_BLANK;
      4'hC:    code = hex_mode ? SEG_C : SEG_BLANK;
      4'hD:    code = hex_mode ? SEG_D : SEG_BLANK;
      4'hE:    code = hex_mode ? SEG_E : SEG_BLANK;
      default: code = hex_mode ? SEG_F : SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_decoder.sv
// Combinational decode of the currently scanned nibble into an active-high
// segment code; a blanked digit yields all segments off.
module seg_nibble_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  input  logic       i_blank,
  output logic [6:0] o_code
);

  // Blanking overrides the decoded value.
  always_comb begin
    o_code = i_blank ? SEG_BLANK : seg_decode(i_nibble, i_hex_mode);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver. Inputs are latched into a
// shadow copy once per frame so a digit never changes mid-frame; segment,
// decimal point and anode outputs are registered together so they switch on
// the same edge.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_hex_mode,
  input  logic                    i_blank_lz,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]        r_prescaler;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_prime;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_en;
  logic                    r_sh_hex;
  logic                    r_sh_blz;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_capture;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_nibble;
  logic                    w_sel_dp;
  logic                    w_sel_en;
  logic                    w_sel_blank;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_code;

  assign w_tick    = (r_prescaler == PRE_LAST);
  assign w_wrap    = w_tick && (r_idx == IDX_LAST);
  assign w_capture = r_prime || w_wrap;

  // Refresh prescaler and scan index; frame_done marks the index wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prescaler  <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_prescaler  <= w_tick ? '0 : r_prescaler + 1'b1;
      r_frame_done <= w_wrap;
      if (w_wrap)      r_idx <= '0;
      else if (w_tick) r_idx <= r_idx + 1'b1;
    end
  end

  // Shadow capture on the first edge after reset and at every frame wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prime     <= 1'b1;
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
      r_sh_hex    <= 1'b0;
      r_sh_blz    <= 1'b0;
    end else begin
      r_prime <= 1'b0;
      if (w_capture) begin
        r_sh_digits <= i_digits_in;
        r_sh_dp     <= i_dp_in;
        r_sh_en     <= i_digit_en;
        r_sh_hex    <= i_hex_mode;
        r_sh_blz    <= i_blank_lz;
      end
    end
  end

  // Leading-zero mask: digit i blanks when it and every higher nibble are 0.
  always_comb begin
    logic w_run;
    w_lz_mask = '0;
    w_run     = r_sh_blz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_run        = w_run && (r_sh_digits[4*i +: 4] == 4'd0);
      w_lz_mask[i] = w_run;
    end
  end

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    w_nibble    = '0;
    w_sel_dp    = 1'b0;
    w_sel_en    = 1'b0;
    w_sel_blank = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_sh_digits[4*i +: 4];
        w_sel_dp    = r_sh_dp[i];
        w_sel_en    = r_sh_en[i];
        w_sel_blank = w_lz_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seg_nibble_decoder u_decoder (
    .i_nibble   (w_nibble),
    .i_hex_mode (r_sh_hex),
    .i_blank    (w_sel_blank),
    .o_code     (w_code)
  );

  // Output register; polarity inversion happens only here. A disabled digit
  // keeps its anode and segments dark for the whole slot.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
      r_an  <= {NUM_DIGITS{AN_INV}};
    end else if (w_sel_en) begin
      r_seg <= w_code ^ {7{SEG_INV}};
      r_dp  <= w_sel_dp ^ SEG_INV;
      r_an  <= w_onehot ^ {NUM_DIGITS{AN_INV}};
    end else begin
      r_seg <= {7{SEG_INV}};
      r_dp  <= SEG_INV;
      r_an  <= {NUM_DIGITS{AN_INV}};
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode or common-cathode seven-segment display. It scans one digit at a time at a programmable refresh rate and decodes BCD or hex nibbles per digit. It supports per-digit decimal points, per-digit enables and leading-zero blanking. It sits between the datapath's packed digit outputs and the board display pins, replacing per-digit static decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment/dp pins active-low, 0 = active-high
AN_ACTIVE_LOW, 1, 1 = anode/digit-select pins active-low, 0 = active-high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant, rightmost)
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  1 = digit may light; 0 = digit permanently dark
hex_mode  in  1  1 = nibbles 10..15 shown as A b C d E F; 0 = shown blank
blank_lz  in  1  1 = suppress leading zeros
seg  out  7  segments {g,f,e,d,c,b,a} = seg[6:0], polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when a full scan frame completes

Behaviour:
- Clock and reset: single clock domain (clk). reset is asynchronous and active-high.
- Reset values:
  - Prescaler, digit index (idx) and shadow registers are 0.
  - seg, dp and an are all at their inactive level (active-low defaults: seg=7'h7F, dp=1, an=all 1s).
  - frame_done is 0.
  - A prime flag is set.
- Prescaler: counts 0..REFRESH_DIV-1, then wraps. tick = (prescaler == REFRESH_DIV-1).
- Scan index: on tick, idx advances by 1. When idx == NUM_DIGITS-1 on tick, idx wraps to 0 and frame_done pulses for exactly that one cycle.
- Shadow capture (tear-free display): digits_in, dp_in, digit_en, hex_mode and blank_lz are registered into shadow registers on:
  - the first clk edge after reset deasserts (prime flag clears on that edge), and
  - every frame wrap (same edge as idx 0->... wrap, i.e. same edge frame_done is asserted).
  Input changes between captures have no visible effect.
- Decode table, value -> {g..a} active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - With hex_mode=1: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - With hex_mode=0: values 10..15 give all segments off.
- Leading-zero blanking: digit i (i>=1) is blanked when blank_lz=1 and shadow nibbles NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked by this rule. dp on a blanked digit is still shown if requested.
- Dark digit: digit_en[i]=0 drives an inactive and seg/dp off for the whole slot. A blanked or value-blank digit keeps its anode active with segments off.
- Output timing: seg, dp and an are registered from the current idx and shadow. They change one clk after idx changes, and all three change on the same edge (no anode/segment mismatch cycle). Per-digit latency from tick is 1 clk. Every lit digit is active for exactly REFRESH_DIV cycles.
- Polarity: inversion is applied at the output register only.
- NUM_DIGITS=1: idx stays 0, frame_done pulses on every tick.
- Reset mid-frame: outputs go inactive immediately (asynchronously). Scanning restarts from digit 0 with a fresh capture after release.

Decomposition:
- Package seven_seg_pkg:
  - segment code constants SEG_0..SEG_F and SEG_BLANK
  - decode function (nibble, hex_mode) -> 7-bit code
- Sub-module seg_nibble_decoder: combinational nibble/hex_mode/blank -> 7-bit code. Instantiated once on the selected digit.
- The top level holds the prescaler, idx, shadow registers, the LZ-blank mask and the output registers.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, active-low):
- Reset: hold reset -> seg=7'h7F, dp=1, an=4'hF, frame_done=0. After release -> an=4'b1110 within 2 clks, then digit 1 follows 4 clks later, digits advance every 4 clks, and frame_done pulses every 16 clks.
- digits_in=16'h1234, blank_lz=0 -> digit0 slot: seg=7'h19, an=4'b1110. digit1: seg=7'h30, an=4'b1101. digit3: seg=7'h79, an=4'b0111.
- digits_in=16'h00AF, hex_mode=1, blank_lz=1 -> digit0 seg=7'h0E, digit1 seg=7'h08, digits 2,3 seg=7'h7F with anodes active. With hex_mode=0, digit0 and digit1 are also 7'h7F.
- Tear-free update: change digits_in from 16'h1111 to 16'h2222 during the digit-1 slot -> digits 2,3 still show 1 (seg=7'h79). All digits show 2 (seg=7'h24) starting with the digit-0 slot after frame_done.
- digit_en=4'b0101, dp_in=4'b0001, digits_in=16'h0000, blank_lz=0 -> digit0 seg=7'h40 with dp=0. Slots 1 and 3 have an=4'hF and seg=7'h7F. digit 2 shows seg=7'h40.
- Assert reset during the digit-2 slot -> seg, an and dp go inactive in the same cycle with no clock edge required. After release, scanning restarts at digit 0 with a fresh capture.
